// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: game-flow controller for a four-colour Simon memory game.
// A free-running LFSR seeds a 16-colour sequence at game start; each round the
// display block replays the first N+1 colours, then the player must repeat them.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               level; starts a game from IDLE, FAIL or WIN
//   btn_valid/colour    one-cycle player press and its colour
//   complete_display    one-cycle done pulse from the display block
//   rst_display         reset to the display block (high in IDLE/LOAD)
//   en_display          one-cycle start pulse on each SHOW entry
//   seq_out             16 colours, colour k at bits [2k+1:2k]
//   round_ctr           round N shows/expects N+1 colours
//   state_o             FSM state code
//   game_over/game_win  high while in FAIL / WIN
//   timeout_flag        high in FAIL when caused by player inactivity
//
// Optional feature: define SIMON_INPUT_TIMEOUT_EN to build the input
// inactivity timer (limit TIMEOUT_CYCLES); otherwise INPUT waits forever.
module simon_game_ctrl #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        btn_valid,
  input  logic [1:0]  btn_colour,
  input  logic        complete_display,
  output logic        rst_display,
  output logic        en_display,
  output logic [31:0] seq_out,
  output logic [3:0]  round_ctr,
  output logic [2:0]  state_o,
  output logic        game_over,
  output logic        game_win,
  output logic        timeout_flag
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SHOW     = 3'd2;
  localparam logic [2:0] S_INPUT    = 3'd3;
  localparam logic [2:0] S_ROUND_OK = 3'd4;
  localparam logic [2:0] S_FAIL     = 3'd5;
  localparam logic [2:0] S_WIN      = 3'd6;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [3:0]  LAST_ROUND = 4'd15;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_lfsr;
  logic [31:0] r_seq;
  logic [3:0]  r_round;
  logic [3:0]  r_idx;
  logic        r_rst_display;
  logic        r_en_display;
  logic        r_game_over;
  logic        r_game_win;
  logic        r_timeout_flag;
  logic [1:0]  w_exp_colour;
  logic        w_tmo_hit;

  assign w_exp_colour = r_seq[{r_idx, 1'b0} +: 2];

`ifdef SIMON_INPUT_TIMEOUT_EN
  logic [23:0] r_tmo_cnt;

  // Inactivity counter: cleared on INPUT entry and on every press in INPUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= 24'd0;
    end else if ((r_state == S_SHOW) && complete_display) begin
      r_tmo_cnt <= 24'd0;
    end else if (r_state == S_INPUT) begin
      if (btn_valid) r_tmo_cnt <= 24'd0;
      else           r_tmo_cnt <= r_tmo_cnt + 24'd1;
    end
  end

  assign w_tmo_hit = (r_state == S_INPUT) && !btn_valid &&
                     (r_tmo_cnt == TIMEOUT_CYCLES - 24'd1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_tmo_hit        = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_FAIL, S_WIN: if (start) w_next = S_LOAD;
      S_LOAD:                w_next = S_SHOW;
      S_SHOW:                if (complete_display) w_next = S_INPUT;
      S_INPUT: begin
        if (btn_valid) begin
          if (btn_colour != w_exp_colour) w_next = S_FAIL;
          else if (r_idx == r_round)      w_next = S_ROUND_OK;
        end else if (w_tmo_hit) begin
          w_next = S_FAIL;
        end
      end
      S_ROUND_OK:            w_next = (r_round == LAST_ROUND) ? S_WIN : S_SHOW;
      default:               w_next = S_IDLE;
    endcase
  end

  // State, LFSR, game data and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_lfsr         <= 32'h0000_0001;
      r_seq          <= 32'd0;
      r_round        <= 4'd0;
      r_idx          <= 4'd0;
      r_rst_display  <= 1'b1;
      r_en_display   <= 1'b0;
      r_game_over    <= 1'b0;
      r_game_win     <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      // Galois right-shift LFSR; nonzero seed keeps it out of the lock-up state.
      r_lfsr  <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
      r_state <= w_next;

      // Outputs are registered from the next state so they align with state_o.
      r_rst_display <= (w_next == S_IDLE) || (w_next == S_LOAD);
      r_en_display  <= (w_next == S_SHOW) && (r_state != S_SHOW);
      r_game_over   <= (w_next == S_FAIL);
      r_game_win    <= (w_next == S_WIN);
      // Flag survives while FAIL is held; set only by a timeout-caused entry.
      r_timeout_flag <= (w_next == S_FAIL) &&
                        ((r_state == S_FAIL) ? r_timeout_flag : w_tmo_hit);

      case (r_state)
        S_LOAD: begin
          r_seq   <= r_lfsr;
          r_round <= 4'd0;
          r_idx   <= 4'd0;
        end
        S_SHOW: if (complete_display) r_idx <= 4'd0;
        S_INPUT: begin
          if (btn_valid && (btn_colour == w_exp_colour) && (r_idx != r_round))
            r_idx <= r_idx + 4'd1;
        end
        S_ROUND_OK: if (r_round != LAST_ROUND) r_round <= r_round + 4'd1;
        default: ;
      endcase
    end
  end

  assign rst_display  = r_rst_display;
  assign en_display   = r_en_display;
  assign seq_out      = r_seq;
  assign round_ctr    = r_round;
  assign state_o      = r_state;
  assign game_over    = r_game_over;
  assign game_win     = r_game_win;
  assign timeout_flag = r_timeout_flag;

endmodule
